// File: rtl/blk_timing.sv
// Upstream timing stage for the per-block luminance buffer: tracks block geometry
// from DE/VSYNC, forwards pixels with one cycle of latency and emits save strobes.
module blk_timing #(
  parameter int HBLKS = 10,
  parameter int VBLKS = 10,
  parameter int BLK_W = 30,
  parameter int BLK_H = 30,
  parameter int V_DLY = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [23:0] wd_i,
  input  logic        clr_err_i,
  output logic        de_o,
  output logic [23:0] wd_o,
  output logic        h_save_o,
  output logic        v_save_o,
  output logic        frame_o,
  output logic        err_o
);

  localparam int PX_W  = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int HB_W  = $clog2(HBLKS + 1);
  localparam int LN_W  = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam int VB_W  = $clog2(VBLKS + 1);
  localparam int CNT_W = $clog2(V_DLY);

  localparam logic [PX_W-1:0]  PX_LAST = PX_W'(BLK_W - 1);
  localparam logic [HB_W-1:0]  HB_END  = HB_W'(HBLKS);
  localparam logic [LN_W-1:0]  LN_LAST = LN_W'(BLK_H - 1);
  localparam logic [VB_W-1:0]  VB_END  = VB_W'(VBLKS);
  // The start decision lands one cycle after the final h_save_o and v_save_o is
  // registered, so the countdown covers V_DLY minus those two cycles.
  localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(V_DLY - 2);

  typedef enum logic {CD_IDLE, CD_COUNT} cd_state_e;

  cd_state_e        cd_state_q, cd_state_d;
  logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;
  logic [PX_W-1:0]  px_q, px_d, px_b;
  logic [HB_W-1:0]  hb_q, hb_d, hb_b;
  logic [LN_W-1:0]  ln_q, ln_d, ln_b;
  logic [VB_W-1:0]  vb_q, vb_d, vb_b;
  logic             vs_q, de_q, h_save_q, v_save_q, v_save_d, frame_q, err_q, err_d;
  logic             frame_seen_q;
  logic [23:0]      wd_q;

  logic vs_rise, in_row, active, px_wrap, line_end, row_done, err_set;

  assign vs_rise = vs_i & ~vs_q;

  // A frame start clears position before the same-cycle pixel is counted.
  assign px_b = vs_rise ? '0 : px_q;
  assign hb_b = vs_rise ? '0 : hb_q;
  assign ln_b = vs_rise ? '0 : ln_q;
  assign vb_b = vs_rise ? '0 : vb_q;

  assign in_row   = (hb_b != HB_END) && (vb_b != VB_END);
  assign active   = de_i & in_row;
  assign px_wrap  = active && (px_b == PX_LAST);
  assign line_end = de_q & ~de_i & ~vs_rise;
  assign row_done = line_end && (vb_q != VB_END) && (ln_q == LN_LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    px_d = px_b;
    hb_d = hb_b;
    ln_d = ln_b;
    vb_d = vb_b;
    if (active) begin
      if (px_wrap) begin
        px_d = '0;
        hb_d = hb_b + 1'b1;
      end else begin
        px_d = px_b + 1'b1;
      end
    end else if (line_end && (vb_q != VB_END)) begin
      px_d = '0;
      hb_d = '0;
      if (ln_q == LN_LAST) begin
        ln_d = '0;
        vb_d = vb_q + 1'b1;
      end else begin
        ln_d = ln_q + 1'b1;
      end
    end
  end

  always_comb begin
    cd_state_d = cd_state_q;
    cd_cnt_d   = cd_cnt_q;
    v_save_d   = 1'b0;
    if (vs_rise) begin
      cd_state_d = CD_IDLE;
      cd_cnt_d   = '0;
    end else begin
      unique case (cd_state_q)
        CD_IDLE: begin
          if (row_done) begin
            cd_state_d = CD_COUNT;
            cd_cnt_d   = CD_LOAD;
          end
        end
        CD_COUNT: begin
          if (cd_cnt_q == '0) begin
            v_save_d   = 1'b1;
            cd_state_d = CD_IDLE;
          end else begin
            cd_cnt_d = cd_cnt_q - 1'b1;
          end
          if (row_done) begin
            cd_state_d = CD_COUNT;
            cd_cnt_d   = CD_LOAD;
          end
        end
        default: cd_state_d = CD_IDLE;
      endcase
    end
  end

  // Geometry errors: overflow pixel, ragged line, DE inside the countdown, short frame.
  assign err_set = (de_i & ~in_row)
                 | (line_end & ((px_q != '0) || (hb_q != HB_END)))
                 | (de_i & (cd_state_q == CD_COUNT) & ~vs_rise)
                 | (vs_rise & frame_seen_q & (vb_q != VB_END));

  assign err_d = clr_err_i ? 1'b0 : (err_q | err_set);

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race the readers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cd_state_q   <= CD_IDLE;
      cd_cnt_q     <= '0;
      px_q         <= '0;
      hb_q         <= '0;
      ln_q         <= '0;
      vb_q         <= '0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      wd_q         <= '0;
      h_save_q     <= 1'b0;
      v_save_q     <= 1'b0;
      frame_q      <= 1'b0;
      err_q        <= 1'b0;
      frame_seen_q <= 1'b0;
    end else begin
      cd_state_q   <= cd_state_d;
      cd_cnt_q     <= cd_cnt_d;
      px_q         <= px_d;
      hb_q         <= hb_d;
      ln_q         <= ln_d;
      vb_q         <= vb_d;
      vs_q         <= vs_i;
      de_q         <= de_i;
      wd_q         <= wd_i;
      h_save_q     <= px_wrap;
      v_save_q     <= v_save_d;
      frame_q      <= vs_rise;
      err_q        <= err_d;
      frame_seen_q <= frame_seen_q | vs_rise;
    end
  end

  assign de_o     = de_q;
  assign wd_o     = wd_q;
  assign h_save_o = h_save_q;
  assign v_save_o = v_save_q;
  assign frame_o  = frame_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_blk_timing.sv
// Directed bench for blk_timing with a small geometry (4x3 blocks of 5x2 pixels).
`timescale 1ns/1ps
module tb_blk_timing;

  localparam int HBLKS = 4;
  localparam int VBLKS = 3;
  localparam int BLK_W = 5;
  localparam int BLK_H = 2;
  localparam int V_DLY = 8;
  localparam int LINE  = HBLKS * BLK_W;

  logic        clk = 1'b0;
  logic        rst_ni, vs_i, de_i, clr_err_i;
  logic [23:0] wd_i;
  logic        de_o, h_save_o, v_save_o, frame_o, err_o;
  logic [23:0] wd_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_h   = 0;
  int vs_got[$];
  int vs_exp[$];

  blk_timing #(
    .HBLKS(HBLKS), .VBLKS(VBLKS), .BLK_W(BLK_W), .BLK_H(BLK_H), .V_DLY(V_DLY)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .vs_i     (vs_i),
    .de_i     (de_i),
    .wd_i     (wd_i),
    .clr_err_i(clr_err_i),
    .de_o     (de_o),
    .wd_o     (wd_o),
    .h_save_o (h_save_o),
    .v_save_o (v_save_o),
    .frame_o  (frame_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst_ni && v_save_o) vs_got.push_back(cyc);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n DE pixels then blank idle cycles; checks forwarding and h_save pattern.
  task automatic send_line(input int n, input int blank);
    int          hcnt;
    logic [23:0] pix;
    logic        exp_h;
    hcnt = 0;
    for (int i = 0; i < n; i++) begin
      pix  = 24'($urandom);
      de_i = 1'b1;
      wd_i = pix;
      tick();
      check("de_o", de_o, 1);
      check("wd_o", wd_o, pix);
      exp_h = (i % BLK_W == BLK_W - 1) && (i < LINE);
      check("h_save_o", h_save_o, exp_h);
      if (i == 0) check("frame_o_idle", frame_o, 0);
      if (h_save_o) begin
        hcnt++;
        last_h = cyc;
      end
    end
    de_i = 1'b0;
    wd_i = '0;
    for (int b = 0; b < blank; b++) begin
      tick();
      if (b == 0) begin
        check("de_o_off", de_o, 0);
        check("h_save_off", h_save_o, 0);
      end
    end
    check("h_cnt", hcnt, ((n < LINE) ? n : LINE) / BLK_W);
  endtask

  task automatic nominal_frame();
    for (int l = 0; l < 2 * VBLKS; l++) begin
      send_line(LINE, 20);
      vs_i = 1'b0;
      if (l % BLK_H == BLK_H - 1) vs_exp.push_back(last_h + V_DLY);
    end
  endtask

  task automatic check_vsave(input string tag);
    int n;
    check({tag, "_vsave_cnt"}, vs_got.size(), vs_exp.size());
    n = (vs_got.size() < vs_exp.size()) ? vs_got.size() : vs_exp.size();
    for (int i = 0; i < n; i++) check({tag, "_vsave_cyc"}, vs_got[i], vs_exp[i]);
    vs_got.delete();
    vs_exp.delete();
  endtask

  task automatic new_frame();
    vs_i = 1'b1;
    tick();
    check("frame_o_pulse", frame_o, 1);
    vs_i = 1'b0;
    tick();
    check("frame_o_drop", frame_o, 0);
  endtask

  task automatic clr_pulse();
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    check("err_cleared", err_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0; vs_i = 1'b0; de_i = 1'b0; wd_i = '0; clr_err_i = 1'b0;
    repeat (3) tick();
    check("rst_de_o", de_o, 0);
    check("rst_err_o", err_o, 0);
    rst_ni = 1'b1;
    tick();

    // 1: reset in the middle of a line
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      de_i = 1'b1;
      wd_i = 24'hC0FFEE;
      tick();
    end
    check("pre_rst_de_o", de_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_de_o", de_o, 0);
    check("async_wd_o", wd_o, 0);
    check("async_h_save", h_save_o, 0);
    check("async_v_save", v_save_o, 0);
    check("async_frame", frame_o, 0);
    check("async_err", err_o, 0);
    repeat (2) tick();
    check("hold_de_o", de_o, 0);
    rst_ni = 1'b1;
    de_i   = 1'b0;
    wd_i   = '0;
    tick();
    check("frame_before_vs", frame_o, 0);
    vs_i = 1'b1;
    tick();
    check("frame_after_rst", frame_o, 1);

    // 2: nominal frame, vs still high during the first line
    nominal_frame();
    check_vsave("nominal");
    check("nominal_err", err_o, 0);

    // 3: long line
    new_frame();
    check("no_short_after_full", err_o, 0);
    send_line(LINE + 3, 0);
    check("err_long", err_o, 1);
    repeat (10) tick();
    check("err_sticky", err_o, 1);
    clr_pulse();
    tick();
    check("err_stays_clear", err_o, 0);

    // 4: short line; the frame edge raises a short-frame error that clr overrides
    vs_i = 1'b1;
    clr_err_i = 1'b1;
    tick();
    check("frame_o_t4", frame_o, 1);
    check("clr_priority", err_o, 0);
    vs_i = 1'b0;
    clr_err_i = 1'b0;
    tick();
    check("err_after_clr_prio", err_o, 0);
    send_line(LINE - 2, 0);
    check("err_before_end", err_o, 0);
    tick();
    check("err_short_line", err_o, 1);
    repeat (20) tick();
    check_vsave("short_line");

    // 5: short blanking after the row-final line
    new_frame();
    check("frame_short", err_o, 1);
    clr_pulse();
    send_line(LINE, 20);
    send_line(LINE, 2);
    vs_exp.push_back(last_h + V_DLY);
    check("err_pre_blank", err_o, 0);
    send_line(LINE, 20);
    check("err_short_blank", err_o, 1);
    check_vsave("short_blank");

    // 6: frame edge cancels a pending v_save
    clr_pulse();
    send_line(LINE, 1);
    vs_i = 1'b1;
    tick();
    check("frame_o_cancel", frame_o, 1);
    check("frame_short_row1", err_o, 1);
    vs_i = 1'b0;
    repeat (15) tick();
    check_vsave("cancel");
    clr_pulse();
    nominal_frame();
    check_vsave("after_cancel");
    check("after_cancel_err", err_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blk_timing.md
Name: blk_timing

Overview:
- Upstream timing stage for the per-block luminance buffer.
- Tracks pixel, block-column, line and block-row position from DE/VSYNC, and forwards 24-bit pixels with 1-cycle latency.
- Emits the per-block h_save and per-block-row v_save strobes the buffer accumulates against, plus a sticky geometry-error flag.

Parameters:
HBLKS, 10, blocks per line
VBLKS, 10, block rows per frame
BLK_W, 30, pixels per block horizontally
BLK_H, 30, lines per block vertically
V_DLY, 8, cycles from the last h_save_o of a block row to its v_save_o (min 7)

Ports:
clk_i  in  1  pixel clock
rst_ni  in  1  asynchronous active-low reset
vs_i  in  1  vsync, active high; rising edge marks frame start
de_i  in  1  data enable
wd_i  in  24  RGB pixel {R,G,B}
clr_err_i  in  1  clears err_o
de_o  out  1  de_i delayed 1 cycle
wd_o  out  24  wd_i delayed 1 cycle
h_save_o  out  1  last pixel of a block, aligned with that pixel on wd_o
v_save_o  out  1  one-cycle block-row-complete strobe
frame_o  out  1  one-cycle pulse on detected vs_i rising edge
err_o  out  1  sticky geometry error

Behaviour:
- Reset (async): all outputs 0, all counters 0, vs history 0, countdown idle.
- Counters: px 0..BLK_W-1, hb 0..HBLKS, ln 0..BLK_H-1, vb 0..VBLKS. hb==HBLKS and vb==VBLKS are overflow states.
- Latency: de_o, wd_o, h_save_o are registered and describe input cycle k-1.
- Active pixel (de_i=1, hb<HBLKS, vb<VBLKS):
  - px increments.
  - At px==BLK_W-1: px wraps to 0, hb increments, and h_save_o=1 next cycle.
- Overflow pixel (hb==HBLKS or vb==VBLKS with de_i=1): forwarded on de_o/wd_o, no h_save_o, err_o set.
- Line end (de_i 1->0, detected on the registered de):
  - px<>0 or hb<>HBLKS (short or ragged line) -> err_o set.
  - hb and px cleared.
  - If ln==BLK_H-1 and vb<VBLKS: ln=0, vb++, start countdown. Otherwise ln++.
- Lines with vb==VBLKS only flag errors; they do not change counters.
- Countdown FSM:
  - IDLE -> COUNT on start, loaded so that v_save_o fires exactly V_DLY cycles after the row's final h_save_o.
  - COUNT reaching 0 -> v_save_o=1 for one cycle -> IDLE.
  - de_i=1 seen while in COUNT -> err_o set; the countdown still completes and v_save_o still fires.
  - v_save_o and h_save_o may coincide only in this error case.
- Frame start (vs_i rising edge, vs registered once):
  - frame_o=1 next cycle.
  - px, hb, ln, vb cleared; countdown forced to IDLE, so a pending v_save_o is cancelled.
  - An active pixel in the same cycle is counted as pixel 0 of the new frame.
- Frame end: vb<VBLKS at the next vs_i rising edge (frame short) -> err_o set.
- err_o:
  - Stays 1 until clr_err_i or reset.
  - clr_err_i has priority over a same-cycle set.
  - Does not alter strobe generation.
- vs_i held high: no effect after the edge. de_i during vs_i high is processed normally.

Test Plan:
(Parameters HBLKS=4, VBLKS=3, BLK_W=5, BLK_H=2, V_DLY=8 unless stated.)
1. Reset mid-frame: rst_ni low while de_i=1 -> all outputs 0 immediately. After release, the first vs_i edge gives frame_o=1 one cycle later.
2. Nominal frame (vs edge, 6 lines of 20 DE pixels, 20-cycle blanking):
   - h_save_o on output pixels 4, 9, 14, 19 of every line.
   - de_o/wd_o equal the inputs delayed 1 cycle.
   - v_save_o exactly 8 cycles after the h_save_o of lines 2, 4, 6; three pulses total.
   - err_o=0.
3. Long line (one line of 23 pixels) -> pixels 20..22 forwarded with no h_save_o, err_o=1 and sticky. clr_err_i pulse -> err_o=0 next cycle.
4. Short line (18 pixels) -> h_save_o at 4, 9, 14 only; err_o=1 at line end.
5. Short blanking (de_i rises 3 cycles after line 2 ends) -> v_save_o still at +8 cycles, err_o=1.
6. vs_i edge 2 cycles after line 4 ends -> no v_save_o for row 1, counters reset, frame_o=1, err_o=1 (frame short).
